data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Parametrised data-memory block for the pipelined RISC-V core, replacing the fixed single-cycle word RAM on the MEM stage. It holds the storage array and adds RV32/RV64 sub-word loads and stores (byte/half/word/double with sign or zero extension), a configurable number of wait states with a req/ready handshake the hazard unit uses to stall the pipeline, and misaligned-access detection. Memory contents may be preloaded from a hex file for simulation.

## Interface
- size, 32: data word width in bits; legal values 32 or 64.
- mem_depth, 1024: number of words in the array; power of two.
- WAIT_STATES, 0: extra cycles per access; legal range 0..7.
- INIT_FILE, "": hex file loaded with $readmemh at time 0 if non-empty.
- CLK  in  1  clock; all state updates on the rising edge.
- RSTa  in  1  asynchronous, active-low reset.
- req  in  1  access request, sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- funct3  in  3  RISC-V width code: 000 lb/sb, 001 lh/sh, 010 lw/sw, 011 ld/sd (size=64 only), 100 lbu, 101 lhu, 110 lwu (size=64 only).
- addr  in  32  byte address.
- wdata  in  size  store data; the low bytes are used.
- rdata  out  size  load result, extended to size bits; valid only while ready=1.
- ready  out  1  one-cycle completion pulse.
- misaligned  out  1  qualifies ready: the access was rejected.
- busy  out  1  high while state is not IDLE.

## Operation
- Let B = size/8 byte lanes and OFF = addr[log2(B)-1:0].
- Word index = addr[log2(B) +: log2(mem_depth)]. Upper address bits are ignored, so addresses wrap modulo mem_depth*B.
- The FSM has three states: IDLE, WAIT and RESP.
- In IDLE, when req=1 the block captures we, funct3, addr and wdata into registers. Inputs may change after this.
  - If WAIT_STATES=0 it goes to RESP.
  - Otherwise it goes to WAIT and loads a counter with WAIT_STATES-1.
- In WAIT, the counter decrements each cycle. At 0 the FSM goes to RESP.
- RESP lasts exactly one cycle, then the FSM returns to IDLE.
  - ready=1 and busy=1 throughout RESP.
  - The store commits on the edge that enters RESP.
  - Load data is registered into rdata on that same edge.
- An access is misaligned when OFF is not a multiple of the access size (2/4/8 bytes).
- An illegal funct3 is treated as misaligned: 111 always, 011/110 when size=32, and 100-110 with we=1.
- For a misaligned access:
  - The full latency is still taken.
  - ready=1 and misaligned=1 in RESP.
  - rdata=0 and no memory write occurs.
- Stores:
  - Only the addressed lanes are written, as a read-modify-write of the word.
  - Lane k receives wdata byte (k-OFF).
  - The other lanes are unchanged.
- Loads:
  - The addressed bytes are shifted down to bit 0.
  - Signed codes (000/001/010 when size=64) sign-extend to size bits.
  - u codes, and lw when size=32, zero-extend. ld is unextended.
- req is ignored while busy=1. The requester holds req until it sees ready.
- Reset (RSTa=0), at any time:
  - The FSM goes to IDLE and the counter clears.
  - rdata=0, ready=0, misaligned=0, busy=0.
  - An access still in WAIT is discarded and its store is not performed.
  - The array contents are not cleared.

## Timing
- Latency runs from the req sample edge to ready high: WAIT_STATES+1 cycles.
- With WAIT_STATES=0, req sampled at edge n gives ready high during cycle n+1.
- The FSM is back in IDLE in the cycle after RESP. Peak throughput is one access per WAIT_STATES+2 cycles.
- busy rises the cycle after acceptance and falls together with ready.
- Stall contract: the hazard unit stalls the pipeline while req && !ready. The pipeline drops req in the cycle after ready.
- A load that follows a store to the same word sees the stored data. There is no forwarding path: ordering alone guarantees this.

## Test plan
- Word round trip (size=32, WAIT_STATES=0):
  - sw 0xDEADBEEF to 0x100, then lw 0x100 -> rdata=0xDEADBEEF.
  - ready goes high 1 cycle after each req sample, and busy pulses for 1 cycle.
- Sub-word loads:
  - lb 0x101 -> 0xFFFFFFBE.
  - lbu 0x101 -> 0x000000BE.
  - lh 0x102 -> 0xFFFFDEAD.
  - lhu 0x102 -> 0x0000DEAD.
- Byte-lane store:
  - sb 0x55 to 0x103, then lw 0x100 -> 0x55ADBEEF.
  - sh 0x1234 to 0x100, then lw 0x100 -> 0x55AD1234.
- Misalignment:
  - lw 0x102 and sh 0x101 -> ready=1, misaligned=1, rdata=0.
  - A following lw 0x100 is unchanged at 0x55AD1234.
  - funct3=111 -> misaligned=1.
- Wait states and reset (WAIT_STATES=3):
  - ready rises exactly 4 cycles after acceptance, and req pulses during busy are ignored.
  - sw 0xCAFEF00D to 0x200 with RSTa driven low 2 cycles after acceptance -> all outputs 0 immediately, and after reset lw 0x200 returns its old value.
- Wrap-around at size=64, mem_depth=1024:
  - sd 0x0123456789ABCDEF to 0x2008, then ld 0x0008 -> same value (index wraps).
  - lw 0x000C -> 0x0000000001234567.
  - lwu at size=32 -> misaligned=1.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Data memory for the MEM stage: RV32/RV64 sub-word loads/stores, optional wait
// states with a req/ready handshake, and misaligned/illegal access rejection.
module data_mem_ctrl #(
  parameter int unsigned size        = 32,
  parameter int unsigned mem_depth   = 1024,
  parameter int unsigned WAIT_STATES = 0,
  parameter              INIT_FILE   = ""
) (
  input  logic            CLK,
  input  logic            RSTa,
  input  logic            req,
  input  logic            we,
  input  logic [2:0]      funct3,
  input  logic [31:0]     addr,
  input  logic [size-1:0] wdata,
  output logic [size-1:0] rdata,
  output logic            ready,
  output logic            misaligned,
  output logic            busy
);
  localparam int unsigned NB = size / 8;
  localparam int unsigned OB = $clog2(NB);
  localparam int unsigned AW = $clog2(mem_depth);
  localparam int unsigned IW = OB + AW;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [IW-1:0]   addr_q, addr_d;
  logic [size-1:0] wdata_q, wdata_d;
  logic [size-1:0] rdata_q, rdata_d;
  logic            mis_q, mis_d;

  logic [size-1:0] mem [mem_depth];

  // Upper address bits wrap away.
  logic unused_addr;
  assign unused_addr = ^addr[31:IW];

  // In IDLE the access is taken straight from the ports so a zero-wait
  // access can commit on its own acceptance edge.
  logic            acc_we;
  logic [2:0]      acc_f3;
  logic [IW-1:0]   acc_addr;
  logic [size-1:0] acc_wdata;

  always_comb begin
    if (state_q == IDLE) begin
      acc_we    = we;
      acc_f3    = funct3;
      acc_addr  = addr[IW-1:0];
      acc_wdata = wdata;
    end else begin
      acc_we    = we_q;
      acc_f3    = f3_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

  logic [OB-1:0]   off;
  logic [AW-1:0]   idx;
  logic [3:0]      nbytes;
  logic            bad_f3, unaligned, acc_mis, enter_resp;
  logic [size-1:0] word, shifted, wshift, lane_mask, merged, loaded;

  always_comb begin
    off       = acc_addr[OB-1:0];
    idx       = acc_addr[OB +: AW];
    nbytes    = 4'd1 << acc_f3[1:0];
    bad_f3    = (acc_f3 == 3'b111) ||
                ((size == 32) && (acc_f3 == 3'b011 || acc_f3 == 3'b110)) ||
                (acc_we && acc_f3[2]);
    unaligned = (32'(off) & (32'(nbytes) - 32'd1)) != 32'd0;
    acc_mis   = bad_f3 || unaligned;

    word      = mem[idx];
    shifted   = word >> {off, 3'b000};
    wshift    = acc_wdata << {off, 3'b000};
    lane_mask = '0;
    for (int unsigned k = 0; k < NB; k++) begin
      if (k >= 32'(off) && k < 32'(off) + 32'(nbytes))
        lane_mask[8*k +: 8] = 8'hFF;
    end
    merged = (word & ~lane_mask) | (wshift & lane_mask);

    case (acc_f3)
      3'b000:  loaded = size'($signed(shifted[7:0]));
      3'b001:  loaded = size'($signed(shifted[15:0]));
      3'b010:  loaded = size'($signed(shifted[31:0]));
      3'b100:  loaded = size'(shifted[7:0]);
      3'b101:  loaded = size'(shifted[15:0]);
      3'b110:  loaded = size'(shifted[31:0]);
      default: loaded = shifted;
    endcase

    enter_resp = ((state_q == IDLE) && req && (WAIT_STATES == 0)) ||
                 ((state_q == WAIT) && (cnt_q == '0));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mis_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          f3_d    = funct3;
          addr_d  = addr[IW-1:0];
          wdata_d = wdata;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 3'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 3'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (enter_resp) begin
      rdata_d = acc_mis ? '0 : loaded;
      mis_d   = acc_mis;
    end
  end

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (enter_resp && acc_we && !acc_mis)
      mem[idx] <= merged;
  end

  assign rdata      = rdata_q;
  assign ready      = (state_q == RESP);
  assign misaligned = mis_q;
  assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboarded random/directed bench for data_mem_ctrl across three
// configurations: 32-bit no-wait, 32-bit three-wait, 64-bit one-wait.
module tb_data_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst_s   [3];
    logic        req_s   [3];
    logic        we_s    [3];
    logic [2:0]  f3_s    [3];
    logic [31:0] addr_s  [3];
    logic [63:0] wd_s    [3];
    logic        ready_s [3];
    logic        mis_s   [3];
    logic        busy_s  [3];
    logic [63:0] rd_s    [3];
    logic [31:0] rd0, rd1;
    logic [63:0] rd2;

    always #5 clk = ~clk;

    data_mem_ctrl #(.size(32), .mem_depth(1024), .WAIT_STATES(0)) u_d0 (
        .CLK(clk), .RSTa(rst_s[0]), .req(req_s[0]), .we(we_s[0]), .funct3(f3_s[0]),
        .addr(addr_s[0]), .wdata(wd_s[0][31:0]), .rdata(rd0), .ready(ready_s[0]),
        .misaligned(mis_s[0]), .busy(busy_s[0]));
    data_mem_ctrl #(.size(32), .mem_depth(1024), .WAIT_STATES(3)) u_d1 (
        .CLK(clk), .RSTa(rst_s[1]), .req(req_s[1]), .we(we_s[1]), .funct3(f3_s[1]),
        .addr(addr_s[1]), .wdata(wd_s[1][31:0]), .rdata(rd1), .ready(ready_s[1]),
        .misaligned(mis_s[1]), .busy(busy_s[1]));
    data_mem_ctrl #(.size(64), .mem_depth(1024), .WAIT_STATES(1)) u_d2 (
        .CLK(clk), .RSTa(rst_s[2]), .req(req_s[2]), .we(we_s[2]), .funct3(f3_s[2]),
        .addr(addr_s[2]), .wdata(wd_s[2]), .rdata(rd2), .ready(ready_s[2]),
        .misaligned(mis_s[2]), .busy(busy_s[2]));

    assign rd_s[0] = {32'h0, rd0};
    assign rd_s[1] = {32'h0, rd1};
    assign rd_s[2] = rd2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          d;
        logic [63:0] rd;
        bit          mis;
        bit          chk_rd;
    } exp_t;
    exp_t sbq[$];

    // Byte-addressed reference memory per instance.
    bit [7:0] mm [3][8192];

    function automatic int ws_of(int d);
        return (d == 0) ? 0 : (d == 1) ? 3 : 1;
    endfunction

    function automatic int sz_of(int d);
        return (d == 2) ? 64 : 32;
    endfunction

    function automatic int wrap_of(int d);
        return 1024 * sz_of(d) / 8;
    endfunction

    function automatic bit model_mis(int d, bit w, bit [2:0] f3, bit [31:0] a);
        int n = 1 << f3[1:0];
        if (f3 == 3'd7) return 1'b1;
        if (sz_of(d) == 32 && (f3 == 3'd3 || f3 == 3'd6)) return 1'b1;
        if (w && f3[2]) return 1'b1;
        return (a % n) != 0;
    endfunction

    function automatic logic [63:0] model_load(int d, bit [2:0] f3, bit [31:0] a);
        int          n = 1 << f3[1:0];
        logic [63:0] v = '0;
        bit          sgn;
        for (int i = 0; i < n; i++)
            v = v | (64'(mm[d][(a + i) % wrap_of(d)]) << (8 * i));
        sgn = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2 && sz_of(d) == 64);
        if (sgn && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
        if (sz_of(d) == 32) v = v & 64'hFFFF_FFFF;
        return v;
    endfunction

    function automatic void model_store(int d, bit [2:0] f3, bit [31:0] a, bit [63:0] wd);
        int n = 1 << f3[1:0];
        for (int i = 0; i < n; i++)
            mm[d][(a + i) % wrap_of(d)] = wd[8*i +: 8];
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (ready_s[d] === 1'b1) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ready: dut%0d rdata=%h misaligned=%b", d, rd_s[d], mis_s[d]);
                end else begin
                    e = sbq.pop_front();
                    if (e.d != d || mis_s[d] !== e.mis || (e.chk_rd && rd_s[d] !== e.rd)) begin
                        errors++;
                        $display("FAIL resp dut%0d: got rdata=%h misaligned=%b, expected dut%0d rdata=%h misaligned=%b",
                                 d, rd_s[d], mis_s[d], e.d, e.rd, e.mis);
                    end
                end
            end
        end
    end

    task automatic access(int d, bit w, bit [2:0] f3, bit [31:0] a, bit [63:0] wd,
                          bit wiggle, bit use_exp, logic [63:0] exp_rd);
        exp_t e;
        int   cyc = 0;
        bit   got = 0;
        e.d      = d;
        e.mis    = model_mis(d, w, f3, a);
        e.chk_rd = e.mis || !w;
        e.rd     = e.mis ? 64'd0 : (use_exp ? exp_rd : model_load(d, f3, a));
        if (!e.mis && w) model_store(d, f3, a, wd);
        sbq.push_back(e);

        @(negedge clk);
        req_s[d] = 1'b1; we_s[d] = w; f3_s[d] = f3; addr_s[d] = a; wd_s[d] = wd;
        @(posedge clk);
        while (cyc < 20 && !got) begin
            @(negedge clk);
            cyc++;
            if (ready_s[d] === 1'b1) begin
                got = 1;
            end else if (wiggle) begin
                req_s[d]  = 1'($urandom);
                we_s[d]   = 1'($urandom);
                f3_s[d]   = 3'($urandom);
                addr_s[d] = $urandom;
                wd_s[d]   = {$urandom, $urandom};
            end
        end
        chk($sformatf("latency_dut%0d", d), 64'(got ? cyc : -1), 64'(ws_of(d) + 1));
        chk($sformatf("busy_in_resp_dut%0d", d), 64'(busy_s[d]), 64'd1);
        req_s[d] = 1'b0;
        @(negedge clk);
        chk($sformatf("idle_after_resp_dut%0d", d), 64'({busy_s[d], ready_s[d]}), 64'd0);
    endtask

    task automatic ld(int d, bit [2:0] f3, bit [31:0] a, logic [63:0] expv);
        access(d, 1'b0, f3, a, 64'd0, 1'b0, 1'b1, expv);
    endtask

    task automatic st(int d, bit [2:0] f3, bit [31:0] a, bit [63:0] wd);
        access(d, 1'b1, f3, a, wd, 1'b0, 1'b0, 64'd0);
    endtask

    task automatic rnd_op(int d);
        bit [31:0] a;
        if (d == 2) a = $urandom_range(0, 127) + ($urandom_range(0, 15) << 13);
        else        a = 32'h100 + $urandom_range(0, 127) + ($urandom_range(0, 15) << 12);
        access(d, 1'($urandom), 3'($urandom), a, {$urandom, $urandom}, d == 1, 1'b0, 64'd0);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst_s[d] = 1'b0; req_s[d] = 1'b0; we_s[d] = 1'b0;
            f3_s[d] = '0; addr_s[d] = '0; wd_s[d] = '0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++)
            chk($sformatf("reset_outputs_dut%0d", d),
                {rd_s[d][60:0], ready_s[d], mis_s[d], busy_s[d]}, 64'd0);
        for (int d = 0; d < 3; d++) rst_s[d] = 1'b1;
        @(negedge clk);

        // Fill the random-test regions so every later load hits known bytes.
        for (int i = 0; i < 32; i++) begin
            st(0, 3'b010, 32'h100 + 4 * i, {32'h0, $urandom});
            st(1, 3'b010, 32'h100 + 4 * i, {32'h0, $urandom});
        end
        for (int i = 0; i < 16; i++) st(2, 3'b011, 8 * i, {$urandom, $urandom});

        // 32-bit, zero wait states
        st(0, 3'b010, 32'h100, 64'hDEADBEEF);
        ld(0, 3'b010, 32'h100, 64'hDEADBEEF);
        ld(0, 3'b000, 32'h101, 64'hFFFFFFBE);
        ld(0, 3'b100, 32'h101, 64'h000000BE);
        ld(0, 3'b001, 32'h102, 64'hFFFFDEAD);
        ld(0, 3'b101, 32'h102, 64'h0000DEAD);
        st(0, 3'b000, 32'h103, 64'h55);
        ld(0, 3'b010, 32'h100, 64'h55ADBEEF);
        st(0, 3'b001, 32'h100, 64'h1234);
        ld(0, 3'b010, 32'h100, 64'h55AD1234);
        ld(0, 3'b010, 32'h102, 64'h0);
        st(0, 3'b001, 32'h101, 64'hFFFF);
        ld(0, 3'b010, 32'h100, 64'h55AD1234);
        ld(0, 3'b111, 32'h100, 64'h0);
        ld(0, 3'b110, 32'h100, 64'h0);
        ld(0, 3'b011, 32'h100, 64'h0);
        st(0, 3'b100, 32'h104, 64'h0);

        // 32-bit, three wait states, input churn while busy, reset mid-access
        st(1, 3'b010, 32'h200, 64'h11223344);
        access(1, 1'b0, 3'b010, 32'h200, 64'd0, 1'b1, 1'b1, 64'h11223344);
        @(negedge clk);
        req_s[1] = 1'b1; we_s[1] = 1'b1; f3_s[1] = 3'b010; addr_s[1] = 32'h200; wd_s[1] = 64'hCAFEF00D;
        @(posedge clk);
        repeat (2) @(posedge clk);
        #1 rst_s[1] = 1'b0;
        #1;
        chk("reset_mid_access", {rd_s[1][60:0], ready_s[1], mis_s[1], busy_s[1]}, 64'd0);
        @(negedge clk);
        req_s[1] = 1'b0;
        @(negedge clk);
        rst_s[1] = 1'b1;
        @(negedge clk);
        ld(1, 3'b010, 32'h200, 64'h11223344);

        // 64-bit, one wait state, address wrap
        st(2, 3'b011, 32'h2008, 64'h0123456789ABCDEF);
        ld(2, 3'b011, 32'h0008, 64'h0123456789ABCDEF);
        ld(2, 3'b010, 32'h000C, 64'h0000000001234567);
        ld(2, 3'b010, 32'h0008, 64'hFFFFFFFF89ABCDEF);
        ld(2, 3'b110, 32'h0008, 64'h0000000089ABCDEF);
        ld(2, 3'b000, 32'h0008, 64'hFFFFFFFFFFFFFFEF);
        ld(2, 3'b001, 32'h000E, 64'h0000000000000123);
        ld(2, 3'b011, 32'h000C, 64'h0);

        for (int i = 0; i < 60; i++) begin
            rnd_op(0);
            rnd_op(1);
            rnd_op(2);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
